pulse_stretcher: RTL and testbench

- Output-side counterpart of top_debouncer. The debouncer removes short input glitches; this block does the reverse and stretches short synchronous pulses into human-visible levels with a guaranteed minimum on-time and off-time.
- It sits between internal bus status strobes (1-cycle ack/error/activity) and board LEDs or other slow indicators.
- Single clock domain; value_in is already synchronous to clk.

---
 rtl/pulse_stretcher.sv | 115 +++++++++++
 tb/tb_pulse_stretcher.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/pulse_stretcher.sv
// Stretches 1-cycle strobes into a minimum on-time followed by a minimum off-time.
// Optional macro STRETCH_RETRIGGER_EN: a new edge during the on-time restarts it.
// Ports: clk, rstN (async, active low), value_in -> value_out, busy, dropped.
module pulse_stretcher #(
   parameter int CLK_FREQ = 50,
   parameter int ON_TIME  = 1,
   parameter int OFF_TIME = 1
) (
   input  logic clk,
   input  logic rstN,
   input  logic value_in,
   output logic value_out,
   output logic busy,
   output logic dropped
);

   localparam int ON_CYCLES  = ON_TIME * CLK_FREQ * 1000;
   localparam int OFF_CYCLES = OFF_TIME * CLK_FREQ * 1000;
   localparam int MAX_CYCLES = (ON_CYCLES > OFF_CYCLES) ?
                               ON_CYCLES : OFF_CYCLES;
   localparam int CW = $clog2(MAX_CYCLES) + 1;

   localparam logic [CW-1:0] ON_LAST  = CW'(ON_CYCLES - 1);
   localparam logic [CW-1:0] OFF_LAST = CW'(OFF_CYCLES - 1);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] HOLD = 2'd1;
   localparam logic [1:0] GAP  = 2'd2;

   logic [1:0]    state, state_n;
   logic [CW-1:0] cnt, cnt_n, cnt_inc;
   logic          in_prev;
   logic          pending, pending_n;
   logic          vout_n, drop_n;
   logic          rise;

   assign rise    = value_in & ~in_prev;
   assign cnt_inc = cnt + CW'(1);

   always_comb begin
      state_n   = state;
      cnt_n     = cnt;
      pending_n = pending;
      vout_n    = 1'b0;
      drop_n    = 1'b0;
      unique case (state)
         IDLE: begin
            if (rise) begin
               state_n = HOLD;
               cnt_n   = '0;
               vout_n  = 1'b1;
            end
         end
         HOLD: begin
            vout_n = 1'b1;
            if (cnt < ON_LAST) cnt_n = cnt_inc;
`ifdef STRETCH_RETRIGGER_EN
            if (rise) cnt_n = '0;
`else
            if (rise) drop_n = 1'b1;
`endif
            // Input must have been low for a full sample so the
            // output covers the whole input high time plus one.
            if (cnt >= ON_LAST && !value_in && !in_prev) begin
               state_n = GAP;
               cnt_n   = '0;
               vout_n  = 1'b0;
            end
         end
         GAP: begin
            cnt_n = cnt_inc;
            if (cnt == OFF_LAST) begin
               cnt_n = '0;
               if (pending && rise) drop_n = 1'b1;
               if (pending || rise) begin
                  state_n   = HOLD;
                  pending_n = 1'b0;
                  vout_n    = 1'b1;
               end else begin
                  state_n = IDLE;
               end
            end else if (rise) begin
               // Only one request is queued; later ones are lost.
               if (pending) drop_n = 1'b1;
               else pending_n = 1'b1;
            end
         end
         default: begin
            state_n = IDLE;
            cnt_n   = '0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rstN) begin
      if (!rstN) begin
         state     <= IDLE;
         cnt       <= '0;
         in_prev   <= 1'b0;
         pending   <= 1'b0;
         value_out <= 1'b0;
         busy      <= 1'b0;
         dropped   <= 1'b0;
      end else begin
         state     <= state_n;
         cnt       <= cnt_n;
         in_prev   <= value_in;
         pending   <= pending_n;
         value_out <= vout_n;
         busy      <= (state_n != IDLE);
         dropped   <= drop_n;
      end
   end

endmodule

// File: tb/tb_pulse_stretcher.sv
// Scoreboard bench for pulse_stretcher at 1000/1000-cycle timing.
// Stimulus queues expected output changes; a monitor matches them.
`timescale 1ns/1ps
module tb_pulse_stretcher;

   logic clk = 1'b0;
   logic rstN = 1'b0;
   logic value_in = 1'b0;
   logic value_out, busy, dropped;

   int cyc = 0;
   int nchk = 0;
   int nerr = 0;
   int b, e;

   typedef struct {
      int         c;
      logic [2:0] o;
   } exp_t;

   exp_t q[$];

   pulse_stretcher #(
      .CLK_FREQ(1),
      .ON_TIME(1),
      .OFF_TIME(1)
   ) dut (
      .clk(clk),
      .rstN(rstN),
      .value_in(value_in),
      .value_out(value_out),
      .busy(busy),
      .dropped(dropped)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   function automatic void want(int c, logic [2:0] o);
      exp_t x;
      x.c = c;
      x.o = o;
      q.push_back(x);
   endfunction

   task automatic go_to(int c);
      while (cyc < c) @(negedge clk);
   endtask

   task automatic pulse_at(int c);
      go_to(c);
      value_in = 1'b1;
      @(negedge clk);
      value_in = 1'b0;
   endtask

   // Monitor: outputs as {value_out, busy, dropped}
   initial begin
      logic [2:0] prev, cur;
      exp_t x;
      prev = 3'b000;
      forever begin
         @(posedge clk or negedge rstN);
         #1;
         cur = {value_out, busy, dropped};
         if (!rstN) begin
            nchk++;
            if (cur !== 3'b000) begin
               nerr++;
               $display("FAIL reset@%0d: got %b want 000", cyc, cur);
            end
         end else begin
            if (cur !== prev) begin
               nchk++;
               if (q.size() == 0) begin
                  nerr++;
                  $display("FAIL unexpected@%0d: got %b want no change",
                           cyc, cur);
               end else begin
                  x = q.pop_front();
                  if (x.c != cyc || x.o !== cur) begin
                     nerr++;
                     $display("FAIL change@%0d: got %b want %b@%0d",
                              cyc, cur, x.o, x.c);
                  end
               end
            end
            while (q.size() > 0 && q[0].c < cyc) begin
               x = q.pop_front();
               nchk++;
               nerr++;
               $display("FAIL missing@%0d: got %b want %b@%0d",
                        cyc, cur, x.o, x.c);
            end
         end
         prev = cur;
      end
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog");
   end

   initial begin
      repeat (4) @(negedge clk);
      rstN = 1'b1;
      @(negedge clk);

      // single 1-cycle pulse
      b = cyc; e = b + 1;
      want(e, 3'b110);
      want(e + 1000, 3'b010);
      want(e + 2000, 3'b000);
      pulse_at(b);
      go_to(e + 2050);

      // input held high for 3000 cycles
      b = cyc; e = b + 1;
      want(e, 3'b110);
      want(e + 3001, 3'b010);
      want(e + 4001, 3'b000);
      go_to(b);
      value_in = 1'b1;
      repeat (3000) @(negedge clk);
      value_in = 1'b0;
      go_to(e + 4050);

      // queued request in gap, then a drop in the next gap
      b = cyc; e = b + 1;
      want(e, 3'b110);
      want(e + 1000, 3'b010);
      want(e + 2000, 3'b110);
      want(e + 3000, 3'b010);
      want(e + 3400, 3'b011);
      want(e + 3401, 3'b010);
      want(e + 4000, 3'b110);
      want(e + 5000, 3'b010);
      want(e + 6000, 3'b000);
      pulse_at(b);
      pulse_at(b + 1200);
      pulse_at(b + 3200);
      pulse_at(b + 3400);
      go_to(e + 6050);

      // second edge during the on-time
      b = cyc; e = b + 1;
      want(e, 3'b110);
`ifdef STRETCH_RETRIGGER_EN
      want(e + 1500, 3'b010);
      want(e + 2500, 3'b000);
`else
      want(e + 500, 3'b111);
      want(e + 501, 3'b110);
      want(e + 1000, 3'b010);
      want(e + 2000, 3'b000);
`endif
      pulse_at(b);
      pulse_at(b + 500);
      go_to(e + 2550);

      // async reset in the middle of the on-time
      b = cyc; e = b + 1;
      want(e, 3'b110);
      pulse_at(b);
      go_to(b + 300);
      #2 rstN = 1'b0;
      repeat (3) @(negedge clk);
      rstN = 1'b1;
      @(negedge clk);

      // fresh pulse after reset
      b = cyc; e = b + 1;
      want(e, 3'b110);
      want(e + 1000, 3'b010);
      want(e + 2000, 3'b000);
      pulse_at(b);
      go_to(e + 2050);

      repeat (5) @(negedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", nchk, nerr);
      $finish;
   end

endmodule
